axi_id_remap: RTL and testbench
===============================

Name: axi_id_remap

Overview:
- Sits between a core AXI4 master and an interconnect slave port that has a narrower ID width.
- Replaces blind ID truncation with a remap table:
  - Each distinct in-flight master ID is bound to one narrow slot ID.
  - Responses are translated back to the original ID.
  - Same-ID ordering is preserved and aliasing between different IDs cannot occur.
- Read (AR/R) and write (AW/B) paths use independent tables. The W channel bypasses this block.

Parameters:
- S_ID_W, 5, upstream (core-side) ID width.
- M_ID_W, 2, downstream ID width. Each table has NSLOT = 2**M_ID_W slots.
- MAX_TXN, 8, maximum outstanding transactions per slot.
- AR_PLD_W, 89, packed AR/AW payload width (addr64, len8, size3, burst2, lock1, cache4, prot3, qos4).
- R_PLD_W, 66, packed R payload width (data64, resp2).

Ports:
- clk  input  1  clock.
- arst  input  1  asynchronous reset, active-high.
- s_arvalid/s_arready  in/out  1  upstream AR handshake.
- s_arid  input  S_ID_W  upstream AR ID.
- s_ar_pld  input  AR_PLD_W  AR payload.
- m_arvalid/m_arready  out/in  1  downstream AR handshake.
- m_arid  output  M_ID_W  slot index.
- m_ar_pld  output  AR_PLD_W  AR payload passthrough.
- m_rvalid/m_rready  in/out  1  downstream R handshake.
- m_rid  input  M_ID_W  R slot ID.
- m_rlast  input  1  R last beat.
- m_r_pld  input  R_PLD_W  R payload.
- s_rvalid/s_rready  out/in  1  upstream R handshake.
- s_rid  output  S_ID_W  restored R ID.
- s_rlast  output  1  R last beat.
- s_r_pld  output  R_PLD_W  R payload.
- s_aw*/m_aw*, m_b*/s_b*  mirror of the AR/R set (B payload is bresp, 2 bits, no last).
- rd_idle, wr_idle  output  1  high when the corresponding table is empty.
- id_err  output  1  sticky flag: response arrived on an unallocated slot.

Behaviour:
- Slot state: vld, orig_id[S_ID_W], cnt[clog2(MAX_TXN+1)]. Reset clears all of it.
- Reset values:
  - While arst is high: s_arready=0, m_arvalid=0, s_awready=0, m_awvalid=0, id_err=0, rd_idle=1, wr_idle=1.
  - The R/B paths are combinational passthroughs and do not depend on reset state.
- Request slot selection is combinational and uses registered state only:
  - Hit: a vld slot with orig_id==s_arid exists. Use that slot. If its cnt==MAX_TXN, stall.
  - Miss: allocate the lowest-index non-vld slot. If no slot is free, stall.
  - Stall means m_arvalid=0 and s_arready=0. A different ID never overtakes a stalled request.
- Request handshake:
  - m_arvalid = s_arvalid & ok; s_arready = m_arready & ok.
  - Payload passes through with zero latency; m_arid = the selected slot.
  - On m_arvalid & m_arready: slot.vld=1, orig_id=s_arid, cnt+1.
- Read response path, zero latency:
  - s_rvalid=m_rvalid, m_rready=s_rready, s_rid=orig_id[m_rid], s_rlast=m_rlast, s_r_pld=m_r_pld.
  - On m_rvalid & m_rready & m_rlast: cnt-1. When cnt reaches 0, vld clears at the next edge.
- Write response path: same as read, but decrement on every B handshake (no last).
- Simultaneous allocate and release:
  - Same slot, same cycle: net cnt unchanged; vld stays 1 and orig_id is kept.
  - A slot freed this cycle is not allocatable until the next cycle.
- A response on a non-vld slot:
  - Still forwarded upstream, with s_rid = stale orig_id.
  - Sets id_err (cleared only by reset). cnt does not underflow; it stays 0.
- rd_idle = no vld read slot; wr_idle likewise for write.
- Reset mid-transaction: the table clears immediately. Later responses count as errors per the non-vld rule.
- The block adds no registers on payload paths, so request and response latency is 0 cycles.

Test Plan:
- Distinct IDs: AR IDs 0x13, 0x07, 0x1F, 0x02 back-to-back, m_arready=1 -> m_arid 0,1,2,3; rd_idle=0. A 5th AR with ID 0x04 -> s_arready=0 until a slot frees.
- R translation: R with m_rid=1, rlast=1 -> s_rid=0x07. Slot 1 frees next cycle. A pending AR with ID 0x04 then issues with m_arid=1.
- Same-ID hit: 8 ARs with ID 0x0A -> all m_arid=0, cnt=8. The 9th stalls. One rlast on slot 0 -> the 9th issues the next cycle.
- Same-cycle allocate and release: slot 0 cnt=1, an AR with ID 0x0A accepted while rlast on slot 0 -> cnt stays 1, vld=1, no free-slot allocation.
- Write path: AW IDs 0x11, 0x11, then B on slot 0 twice -> s_bid=0x11 both times; wr_idle returns to 1 after the second B.
- Error and reset: B with m_bid=2 on an empty table -> s_bid forwarded, id_err=1 and held. Assert arst -> id_err=0, all slots empty, s_awready=0 during reset.

Source files
------------

// File: rtl/axi_id_remap.sv
// AXI ID remap: binds each in-flight wide ID to a narrow slot and restores the wide ID on responses.
// Zero latency on all paths; a request stalls (valid/ready both low) when its ID's slot is full or no slot is free.

module id_remap_table #(
  parameter int ID_W    = 5,
  parameter int SLOT_W  = 2,
  parameter int MAX_TXN = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              req_vld,
  input  logic [ID_W-1:0]   req_id,
  input  logic              req_rdy,
  output logic              req_ok,
  output logic [SLOT_W-1:0] req_slot,
  input  logic              rsp_fire,
  input  logic              rsp_last,
  input  logic [SLOT_W-1:0] rsp_slot,
  output logic [ID_W-1:0]   rsp_id,
  output logic              idle,
  output logic              err
);
  localparam int NSLOT = 2 ** SLOT_W;
  localparam int CNT_W = $clog2(MAX_TXN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TXN);

  logic [NSLOT-1:0] vld;
  logic [ID_W-1:0]  orig    [NSLOT];
  logic [CNT_W-1:0] cnt     [NSLOT];
  logic [CNT_W-1:0] cnt_nxt [NSLOT];
  logic [NSLOT-1:0] inc;
  logic [NSLOT-1:0] dec;

  logic              hit;
  logic              free;
  logic [SLOT_W-1:0] hit_slot;
  logic [SLOT_W-1:0] free_slot;
  logic              alloc;

  // Selection looks only at registered state, so a slot released this cycle
  // still reads as occupied and cannot be handed to a new ID until next cycle.
  always_comb begin
    hit       = 1'b0;
    free      = 1'b0;
    hit_slot  = '0;
    free_slot = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!hit && vld[i] && orig[i] == req_id) begin
        hit      = 1'b1;
        hit_slot = SLOT_W'(i);
      end
      if (!free && !vld[i]) begin
        free      = 1'b1;
        free_slot = SLOT_W'(i);
      end
    end
  end

  assign req_slot = hit ? hit_slot : free_slot;
  assign req_ok   = !arst && (hit ? (cnt[hit_slot] != CNT_MAX) : free);
  assign alloc    = req_vld && req_rdy && req_ok;
  assign rsp_id   = orig[rsp_slot];
  assign idle     = ~|vld;

  // A response to an empty slot never decrements, so the counter cannot wrap.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      inc[i]     = alloc && (req_slot == SLOT_W'(i));
      dec[i]     = rsp_fire && rsp_last && (rsp_slot == SLOT_W'(i)) && (cnt[i] != '0);
      cnt_nxt[i] = cnt[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld <= '0;
      err <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        orig[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (rsp_fire && !vld[rsp_slot])
        err <= 1'b1;
      for (int i = 0; i < NSLOT; i++) begin
        cnt[i] <= cnt_nxt[i];
        vld[i] <= (cnt_nxt[i] != '0);
        if (inc[i])
          orig[i] <= req_id;
      end
    end
  end
endmodule

module axi_id_remap #(
  parameter int S_ID_W   = 5,
  parameter int M_ID_W   = 2,
  parameter int MAX_TXN  = 8,
  parameter int AR_PLD_W = 89,
  parameter int R_PLD_W  = 66
) (
  input  logic                clk,
  input  logic                arst,
  // read request
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [S_ID_W-1:0]   s_arid,
  input  logic [AR_PLD_W-1:0] s_ar_pld,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [M_ID_W-1:0]   m_arid,
  output logic [AR_PLD_W-1:0] m_ar_pld,
  // read response
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [M_ID_W-1:0]   m_rid,
  input  logic                m_rlast,
  input  logic [R_PLD_W-1:0]  m_r_pld,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [S_ID_W-1:0]   s_rid,
  output logic                s_rlast,
  output logic [R_PLD_W-1:0]  s_r_pld,
  // write request
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [S_ID_W-1:0]   s_awid,
  input  logic [AR_PLD_W-1:0] s_aw_pld,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [M_ID_W-1:0]   m_awid,
  output logic [AR_PLD_W-1:0] m_aw_pld,
  // write response
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [M_ID_W-1:0]   m_bid,
  input  logic [1:0]          m_b_pld,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [S_ID_W-1:0]   s_bid,
  output logic [1:0]          s_b_pld,
  // status
  output logic                rd_idle,
  output logic                wr_idle,
  output logic                id_err
);
  logic ar_ok;
  logic aw_ok;
  logic rd_err;
  logic wr_err;

  id_remap_table #(
    .ID_W    (S_ID_W),
    .SLOT_W  (M_ID_W),
    .MAX_TXN (MAX_TXN)
  ) u_rd_tbl (
    .clk      (clk),
    .arst     (arst),
    .req_vld  (s_arvalid),
    .req_id   (s_arid),
    .req_rdy  (m_arready),
    .req_ok   (ar_ok),
    .req_slot (m_arid),
    .rsp_fire (m_rvalid && s_rready),
    .rsp_last (m_rlast),
    .rsp_slot (m_rid),
    .rsp_id   (s_rid),
    .idle     (rd_idle),
    .err      (rd_err)
  );

  // B has no last beat: every handshake retires one write.
  id_remap_table #(
    .ID_W    (S_ID_W),
    .SLOT_W  (M_ID_W),
    .MAX_TXN (MAX_TXN)
  ) u_wr_tbl (
    .clk      (clk),
    .arst     (arst),
    .req_vld  (s_awvalid),
    .req_id   (s_awid),
    .req_rdy  (m_awready),
    .req_ok   (aw_ok),
    .req_slot (m_awid),
    .rsp_fire (m_bvalid && s_bready),
    .rsp_last (1'b1),
    .rsp_slot (m_bid),
    .rsp_id   (s_bid),
    .idle     (wr_idle),
    .err      (wr_err)
  );

  assign m_arvalid = s_arvalid && ar_ok;
  assign s_arready = m_arready && ar_ok;
  assign m_ar_pld  = s_ar_pld;

  assign s_rvalid  = m_rvalid;
  assign m_rready  = s_rready;
  assign s_rlast   = m_rlast;
  assign s_r_pld   = m_r_pld;

  assign m_awvalid = s_awvalid && aw_ok;
  assign s_awready = m_awready && aw_ok;
  assign m_aw_pld  = s_aw_pld;

  assign s_bvalid  = m_bvalid;
  assign m_bready  = s_bready;
  assign s_b_pld   = m_b_pld;

  assign id_err    = rd_err || wr_err;
endmodule

// File: tb/tb_axi_id_remap.sv
// Scenario-driven bench for axi_id_remap with a queue scoreboard of expected slot/ID values.
module tb_axi_id_remap;
  localparam int S_ID_W   = 5;
  localparam int M_ID_W   = 2;
  localparam int AR_PLD_W = 89;
  localparam int R_PLD_W  = 66;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                arst;
  logic                s_arvalid, s_arready, m_arvalid, m_arready;
  logic [S_ID_W-1:0]   s_arid;
  logic [AR_PLD_W-1:0] s_ar_pld, m_ar_pld;
  logic [M_ID_W-1:0]   m_arid;
  logic                m_rvalid, m_rready, m_rlast, s_rvalid, s_rready, s_rlast;
  logic [M_ID_W-1:0]   m_rid;
  logic [R_PLD_W-1:0]  m_r_pld, s_r_pld;
  logic [S_ID_W-1:0]   s_rid;
  logic                s_awvalid, s_awready, m_awvalid, m_awready;
  logic [S_ID_W-1:0]   s_awid;
  logic [AR_PLD_W-1:0] s_aw_pld, m_aw_pld;
  logic [M_ID_W-1:0]   m_awid;
  logic                m_bvalid, m_bready, s_bvalid, s_bready;
  logic [M_ID_W-1:0]   m_bid;
  logic [1:0]          m_b_pld, s_b_pld;
  logic [S_ID_W-1:0]   s_bid;
  logic                rd_idle, wr_idle, id_err;

  axi_id_remap dut (
    .clk(clk), .arst(arst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_ar_pld(s_ar_pld),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_ar_pld(m_ar_pld),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rlast(m_rlast), .m_r_pld(m_r_pld),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rlast(s_rlast), .s_r_pld(s_r_pld),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_aw_pld(s_aw_pld),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_aw_pld(m_aw_pld),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_b_pld(m_b_pld),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_b_pld(s_b_pld),
    .rd_idle(rd_idle), .wr_idle(wr_idle), .id_err(id_err)
  );

  int checks = 0;
  int errors = 0;
  logic [M_ID_W-1:0] sb_slot [$];
  logic [S_ID_W-1:0] sb_id   [$];

  // Drivers: present a request and wait (bounded) for its handshake.
  task automatic send_ar(input logic [S_ID_W-1:0] id, output logic [M_ID_W-1:0] slot,
                         output bit got, output bit pld_ok);
    got = 0; slot = '0; pld_ok = 0;
    s_arvalid = 1'b1; s_arid = id;
    s_ar_pld = AR_PLD_W'({$urandom(), $urandom(), $urandom()});
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (m_arvalid && m_arready) begin
        got = 1; slot = m_arid; pld_ok = (m_ar_pld === s_ar_pld);
      end
      @(posedge clk); #1;
    end
    s_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [S_ID_W-1:0] id, output logic [M_ID_W-1:0] slot,
                         output bit got, output bit pld_ok);
    got = 0; slot = '0; pld_ok = 0;
    s_awvalid = 1'b1; s_awid = id;
    s_aw_pld = AR_PLD_W'({$urandom(), $urandom(), $urandom()});
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (m_awvalid && m_awready) begin
        got = 1; slot = m_awid; pld_ok = (m_aw_pld === s_aw_pld);
      end
      @(posedge clk); #1;
    end
    s_awvalid = 1'b0;
  endtask

  task automatic send_r(input logic [M_ID_W-1:0] slot, input logic last,
                        output logic [S_ID_W-1:0] rid, output bit fwd);
    m_rvalid = 1'b1; m_rid = slot; m_rlast = last;
    m_r_pld = R_PLD_W'({$urandom(), $urandom(), $urandom()});
    @(negedge clk);
    rid = s_rid;
    fwd = (s_rvalid === 1'b1) && (s_rlast === last) && (s_r_pld === m_r_pld) && (m_rready === 1'b1);
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  task automatic send_b(input logic [M_ID_W-1:0] slot, output logic [S_ID_W-1:0] bid,
                        output bit fwd);
    m_bvalid = 1'b1; m_bid = slot; m_b_pld = 2'($urandom());
    @(negedge clk);
    bid = s_bid;
    fwd = (s_bvalid === 1'b1) && (s_b_pld === m_b_pld) && (m_bready === 1'b1);
    @(posedge clk); #1;
    m_bvalid = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; s_arvalid = 1'b1; s_awvalid = 1'b1; s_arid = 5'h05; s_awid = 5'h06;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_arready, m_arvalid, s_awready, m_awvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshake: got %b expected 0000", {s_arready, m_arvalid, s_awready, m_awvalid});
    end
    checks++;
    if ({id_err, rd_idle, wr_idle} !== 3'b011) begin
      errors++;
      $display("FAIL reset_status: got %b expected 011", {id_err, rd_idle, wr_idle});
    end
    @(posedge clk); #1;
    arst = 1'b0; s_arvalid = 1'b0; s_awvalid = 1'b0;
  endtask

  task automatic test_distinct_ids();
    logic [S_ID_W-1:0] ids [4];
    logic [M_ID_W-1:0] slot, exp;
    bit got, pok;
    ids = '{5'h13, 5'h07, 5'h1F, 5'h02};
    // downstream backpressure must block acceptance upstream
    m_arready = 1'b0; s_arvalid = 1'b1; s_arid = 5'h13;
    @(negedge clk);
    checks++;
    if (s_arready !== 1'b0 || m_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL ar_backpressure: got rdy=%b vld=%b expected rdy=0 vld=1", s_arready, m_arvalid);
    end
    @(posedge clk); #1;
    m_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_slot.push_back(M_ID_W'(i));
      send_ar(ids[i], slot, got, pok);
      exp = sb_slot.pop_front();
      checks++;
      if (!got || slot !== exp || !pok) begin
        errors++;
        $display("FAIL distinct_ar%0d: got slot %0d (hs=%0d pld=%0d) expected slot %0d", i, slot, got, pok, exp);
      end
    end
    checks++;
    if (rd_idle !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle_busy: got %b expected 0", rd_idle);
    end
    s_arvalid = 1'b1; s_arid = 5'h04;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_arready !== 1'b0 || m_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL full_stall: got rdy=%b vld=%b expected 0/0", s_arready, m_arvalid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r_translation();
    logic [S_ID_W-1:0] rid, eid;
    logic [M_ID_W-1:0] exp;
    logic [S_ID_W-1:0] drain_ids [4];
    bit fwd;
    drain_ids = '{5'h13, 5'h04, 5'h1F, 5'h02};
    sb_id.push_back(5'h07);
    m_rvalid = 1'b1; m_rid = 2'd1; m_rlast = 1'b1;
    m_r_pld = R_PLD_W'({$urandom(), $urandom(), $urandom()});
    @(negedge clk);
    eid = sb_id.pop_front();
    checks++;
    if (s_rid !== eid || s_rvalid !== 1'b1 || s_rlast !== 1'b1 || s_r_pld !== m_r_pld) begin
      errors++;
      $display("FAIL r_translate: got id %0h expected %0h", s_rid, eid);
    end
    checks++;
    if (s_arready !== 1'b0) begin
      errors++;
      $display("FAIL freed_slot_same_cycle: got s_arready %b expected 0", s_arready);
    end
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    sb_slot.push_back(2'd1);
    @(negedge clk);
    exp = sb_slot.pop_front();
    checks++;
    if (m_arvalid !== 1'b1 || s_arready !== 1'b1 || m_arid !== exp) begin
      errors++;
      $display("FAIL realloc: got vld=%b slot=%0d expected vld=1 slot=%0d", m_arvalid, m_arid, exp);
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    sb_id.push_back(5'h13);
    send_r(2'd0, 1'b0, rid, fwd);
    eid = sb_id.pop_front();
    checks++;
    if (rid !== eid || !fwd || rd_idle !== 1'b0) begin
      errors++;
      $display("FAIL r_nonlast: got id %0h idle %b expected id %0h idle 0", rid, rd_idle, eid);
    end
    for (int i = 0; i < 4; i++) begin
      sb_id.push_back(drain_ids[i]);
      send_r(M_ID_W'(i), 1'b1, rid, fwd);
      eid = sb_id.pop_front();
      checks++;
      if (rid !== eid || !fwd) begin
        errors++;
        $display("FAIL r_drain%0d: got id %0h expected %0h", i, rid, eid);
      end
    end
    checks++;
    if (rd_idle !== 1'b1) begin
      errors++;
      $display("FAIL rd_idle_drained: got %b expected 1", rd_idle);
    end
  endtask

  task automatic test_same_id_hit();
    logic [M_ID_W-1:0] slot, exp;
    logic [S_ID_W-1:0] rid, eid;
    bit got, pok, fwd;
    for (int i = 0; i < 8; i++) begin
      sb_slot.push_back(2'd0);
      send_ar(5'h0A, slot, got, pok);
      exp = sb_slot.pop_front();
      checks++;
      if (!got || slot !== exp) begin
        errors++;
        $display("FAIL hit_ar%0d: got slot %0d hs %0d expected slot %0d", i, slot, got, exp);
      end
    end
    s_arvalid = 1'b1; s_arid = 5'h0A;
    @(negedge clk);
    checks++;
    if (s_arready !== 1'b0 || m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL hit_full_stall: got rdy=%b vld=%b expected 0/0", s_arready, m_arvalid);
    end
    @(posedge clk); #1;
    m_rvalid = 1'b1; m_rid = 2'd0; m_rlast = 1'b1;
    @(negedge clk);
    checks++;
    if (s_arready !== 1'b0 || s_rid !== 5'h0A) begin
      errors++;
      $display("FAIL hit_release_cycle: got rdy=%b id=%0h expected rdy=0 id=0a", s_arready, s_rid);
    end
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    @(negedge clk);
    checks++;
    if (m_arvalid !== 1'b1 || m_arid !== 2'd0) begin
      errors++;
      $display("FAIL hit_ninth: got vld=%b slot=%0d expected vld=1 slot=0", m_arvalid, m_arid);
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sb_id.push_back(5'h0A);
      send_r(2'd0, 1'b1, rid, fwd);
      eid = sb_id.pop_front();
      checks++;
      if (rid !== eid || !fwd) begin
        errors++;
        $display("FAIL hit_drain%0d: got id %0h expected %0h", i, rid, eid);
      end
    end
    checks++;
    if (rd_idle !== 1'b0) begin
      errors++;
      $display("FAIL hit_one_left: got idle %b expected 0", rd_idle);
    end
  endtask

  task automatic test_alloc_release();
    logic [M_ID_W-1:0] slot, exp;
    logic [S_ID_W-1:0] rid, eid;
    bit got, pok, fwd;
    s_arvalid = 1'b1; s_arid = 5'h0A;
    m_rvalid = 1'b1; m_rid = 2'd0; m_rlast = 1'b1;
    @(negedge clk);
    checks++;
    if (m_arvalid !== 1'b1 || s_arready !== 1'b1 || m_arid !== 2'd0 || s_rid !== 5'h0A) begin
      errors++;
      $display("FAIL same_cycle: got vld=%b slot=%0d id=%0h expected vld=1 slot=0 id=0a", m_arvalid, m_arid, s_rid);
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    checks++;
    if (rd_idle !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_vld: got idle %b expected 0", rd_idle);
    end
    sb_slot.push_back(2'd1);
    send_ar(5'h15, slot, got, pok);
    exp = sb_slot.pop_front();
    checks++;
    if (!got || slot !== exp) begin
      errors++;
      $display("FAIL same_cycle_next_free: got slot %0d expected %0d", slot, exp);
    end
    sb_id.push_back(5'h15);
    send_r(2'd1, 1'b1, rid, fwd);
    eid = sb_id.pop_front();
    checks++;
    if (rid !== eid || rd_idle !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_r1: got id %0h idle %b expected id %0h idle 0", rid, rd_idle, eid);
    end
    sb_id.push_back(5'h0A);
    send_r(2'd0, 1'b1, rid, fwd);
    eid = sb_id.pop_front();
    checks++;
    if (rid !== eid || rd_idle !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_cnt: got id %0h idle %b expected id %0h idle 1", rid, rd_idle, eid);
    end
  endtask

  task automatic test_write_path();
    logic [M_ID_W-1:0] slot, exp;
    logic [S_ID_W-1:0] bid, eid;
    bit got, pok, fwd;
    for (int i = 0; i < 2; i++) begin
      sb_slot.push_back(2'd0);
      send_aw(5'h11, slot, got, pok);
      exp = sb_slot.pop_front();
      checks++;
      if (!got || slot !== exp || !pok) begin
        errors++;
        $display("FAIL aw%0d: got slot %0d hs %0d pld %0d expected slot %0d", i, slot, got, pok, exp);
      end
    end
    checks++;
    if (wr_idle !== 1'b0 || rd_idle !== 1'b1) begin
      errors++;
      $display("FAIL wr_busy: got wr_idle %b rd_idle %b expected 0/1", wr_idle, rd_idle);
    end
    for (int i = 0; i < 2; i++) begin
      sb_id.push_back(5'h11);
      send_b(2'd0, bid, fwd);
      eid = sb_id.pop_front();
      checks++;
      if (bid !== eid || !fwd || wr_idle !== (i == 1)) begin
        errors++;
        $display("FAIL b%0d: got id %0h idle %b expected id %0h idle %0d", i, bid, wr_idle, eid, i == 1);
      end
    end
  endtask

  task automatic test_error_reset();
    logic [M_ID_W-1:0] slot;
    logic [S_ID_W-1:0] bid, eid;
    bit got, pok, fwd;
    checks++;
    if (id_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean: got %b expected 0", id_err);
    end
    sb_id.push_back(5'h00);
    send_b(2'd2, bid, fwd);
    eid = sb_id.pop_front();
    checks++;
    if (bid !== eid || !fwd || id_err !== 1'b1) begin
      errors++;
      $display("FAIL err_b: got id %0h fwd %0d err %b expected id %0h fwd 1 err 1", bid, fwd, id_err, eid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (id_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", id_err);
    end
    send_aw(5'h09, slot, got, pok);
    checks++;
    if (!got || slot !== 2'd0 || wr_idle !== 1'b0) begin
      errors++;
      $display("FAIL err_aw: got slot %0d hs %0d idle %b expected slot 0 hs 1 idle 0", slot, got, wr_idle);
    end
    arst = 1'b1; s_awvalid = 1'b1; s_awid = 5'h09;
    #2;
    checks++;
    if ({id_err, wr_idle, s_awready, m_awvalid} !== 4'b0100) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 0100", {id_err, wr_idle, s_awready, m_awvalid});
    end
    @(posedge clk); #1;
    arst = 1'b0; s_awvalid = 1'b0;
    sb_id.push_back(5'h00);
    send_b(2'd0, bid, fwd);
    eid = sb_id.pop_front();
    checks++;
    if (bid !== eid || !fwd || id_err !== 1'b1 || wr_idle !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_b: got id %0h err %b idle %b expected id %0h err 1 idle 1", bid, id_err, wr_idle, eid);
    end
  endtask

  initial begin
    arst = 1'b1;
    s_arvalid = 1'b0; s_arid = '0; s_ar_pld = '0; m_arready = 1'b1;
    m_rvalid = 1'b0; m_rid = '0; m_rlast = 1'b0; m_r_pld = '0; s_rready = 1'b1;
    s_awvalid = 1'b0; s_awid = '0; s_aw_pld = '0; m_awready = 1'b1;
    m_bvalid = 1'b0; m_bid = '0; m_b_pld = '0; s_bready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_distinct_ids();
    test_r_translation();
    test_same_id_hit();
    test_alloc_release();
    test_write_path();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
